bcd_entry: RTL and testbench

- Operator number-entry block for the Basys 3 top level. It is the input-side counterpart of the binary-to-BCD display path.
- Four debounced pushbuttons edit a 4-digit decimal number. The digits are echoed on the 7-segment display through the existing ones/tens/hundreds/thousands bus.
- On "enter", the block converts the BCD digits to binary with a sequential multiply-by-10 accumulator. It presents the result to RV32I through a valid/ready handshake.

---
 rtl/bcd_entry_if.sv | 21 ++
 rtl/bcd_entry.sv | 155 +++++++++++++++
 tb/tb_bcd_entry.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/bcd_entry_if.sv
// Result handshake between the number-entry block and its consumer.
// The master drives the value and its valid flag. The slave returns ready.
interface bcd_entry_if #(
    parameter int unsigned OUT_W = 32
);
    logic [OUT_W-1:0] value;
    logic             value_valid;
    logic             value_ready;

    modport master (
        output value,
        output value_valid,
        input  value_ready
    );

    modport slave (
        input  value,
        input  value_valid,
        output value_ready
    );
endinterface

// File: rtl/bcd_entry.sv
// Four-digit decimal entry from debounced pushbuttons.
// BCD-to-binary conversion is a multiply-by-10 accumulator, and the result goes out over a valid/ready handshake.
module bcd_entry #(
    parameter int unsigned DB_CYCLES = 1000000,
    parameter int unsigned OUT_W     = 32
) (
    input  logic        clk_100MHz,
    input  logic        reset,
    input  logic        btn_inc,
    input  logic        btn_dec,
    input  logic        btn_next,
    input  logic        btn_enter,
    output logic [3:0]  ones,
    output logic [3:0]  tens,
    output logic [3:0]  hundreds,
    output logic [3:0]  thousands,
    output logic [1:0]  sel,
    output logic        busy,
    bcd_entry_if.master result
);

    localparam int unsigned CNT_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

    typedef enum logic [1:0] {
        EDIT,
        CONVERT,
        VALID
    } state_t;

    // Button vector order: {enter, next, dec, inc}
    logic [3:0]       btn_raw;
    logic [3:0]       sync1;
    logic [3:0]       sync2;
    logic [3:0]       level;
    logic [3:0]       level_q;
    logic [3:0]       pulse;
    logic [CNT_W-1:0] db_cnt [4];

    assign btn_raw = {btn_enter, btn_next, btn_dec, btn_inc};

    always_ff @(posedge clk_100MHz or negedge reset) begin
        if (!reset) begin
            sync1   <= '0;
            sync2   <= '0;
            level   <= '0;
            level_q <= '0;
            for (int unsigned i = 0; i < 4; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            sync1   <= btn_raw;
            sync2   <= sync1;
            level_q <= level;
            for (int unsigned i = 0; i < 4; i++) begin
                if (sync2[i] == level[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == CNT_MAX) begin
                    level[i]  <= sync2[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign pulse = level & ~level_q;

    state_t           state, state_nx;
    logic [3:0]       digit    [4];
    logic [3:0]       digit_nx [4];
    logic [1:0]       sel_q, sel_nx;
    logic [1:0]       idx, idx_nx;
    logic [13:0]      acc, acc_nx, acc_step;
    logic [OUT_W-1:0] value_q, value_nx;
    logic             valid_q, valid_nx;

    // acc*10 + digit, built from shifts so no multiplier is needed
    assign acc_step = {acc[10:0], 3'b000} + {acc[12:0], 1'b0} + {10'd0, digit[idx]};

    always_comb begin
        state_nx = state;
        digit_nx = digit;
        sel_nx   = sel_q;
        idx_nx   = idx;
        acc_nx   = acc;
        value_nx = value_q;
        valid_nx = valid_q;
        case (state)
            EDIT: begin
                if (pulse[3]) begin
                    acc_nx   = '0;
                    idx_nx   = 2'd3;
                    state_nx = CONVERT;
                end else if (pulse[2]) begin
                    sel_nx = sel_q + 2'd1;
                end else if (pulse[0]) begin
                    digit_nx[sel_q] = (digit[sel_q] == 4'd9) ? 4'd0 : digit[sel_q] + 4'd1;
                end else if (pulse[1]) begin
                    digit_nx[sel_q] = (digit[sel_q] == 4'd0) ? 4'd9 : digit[sel_q] - 4'd1;
                end
            end
            CONVERT: begin
                acc_nx = acc_step;
                if (idx == 2'd0) begin
                    value_nx = OUT_W'(acc_step);
                    valid_nx = 1'b1;
                    state_nx = VALID;
                end else begin
                    idx_nx = idx - 2'd1;
                end
            end
            VALID: begin
                if (valid_q && result.value_ready) begin
                    valid_nx = 1'b0;
                    state_nx = EDIT;
                end
            end
            default: state_nx = EDIT;
        endcase
    end

    always_ff @(posedge clk_100MHz or negedge reset) begin
        if (!reset) begin
            state   <= EDIT;
            sel_q   <= '0;
            idx     <= '0;
            acc     <= '0;
            value_q <= '0;
            valid_q <= 1'b0;
            for (int unsigned i = 0; i < 4; i++) begin
                digit[i] <= '0;
            end
        end else begin
            state   <= state_nx;
            digit   <= digit_nx;
            sel_q   <= sel_nx;
            idx     <= idx_nx;
            acc     <= acc_nx;
            value_q <= value_nx;
            valid_q <= valid_nx;
        end
    end

    assign ones               = digit[0];
    assign tens               = digit[1];
    assign hundreds           = digit[2];
    assign thousands          = digit[3];
    assign sel                = sel_q;
    assign busy               = (state != EDIT);
    assign result.value       = value_q;
    assign result.value_valid = valid_q;

endmodule

// File: tb/tb_bcd_entry.sv
// Testbench for bcd_entry: random entries scored against a decimal reference model.
// Converted results are checked by an independent monitor.
module tb_bcd_entry;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       btn_inc = 1'b0;
    logic       btn_dec = 1'b0;
    logic       btn_next = 1'b0;
    logic       btn_enter = 1'b0;
    logic [3:0] ones, tens, hundreds, thousands;
    logic [1:0] sel;
    logic       busy;

    bcd_entry_if #(.OUT_W(32)) bus ();

    always #5 clk = ~clk;

    bcd_entry #(
        .DB_CYCLES(4),
        .OUT_W(32)
    ) dut (
        .clk_100MHz(clk),
        .reset(reset),
        .btn_inc(btn_inc),
        .btn_dec(btn_dec),
        .btn_next(btn_next),
        .btn_enter(btn_enter),
        .ones(ones),
        .tens(tens),
        .hundreds(hundreds),
        .thousands(thousands),
        .sel(sel),
        .busy(busy),
        .result(bus)
    );

    int checks = 0;
    int errors = 0;
    int m_digit[4];
    int m_sel = 0;
    int last_value = 0;
    int exp_q[$];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int model_value();
        return m_digit[3] * 1000 + m_digit[2] * 100 + m_digit[1] * 10 + m_digit[0];
    endfunction

    // Mask order {enter, next, dec, inc}; only the highest-priority press counts
    task automatic model_apply(input logic [3:0] mask);
        if (mask[3]) begin
            last_value = model_value();
            exp_q.push_back(last_value);
        end else if (mask[2]) begin
            m_sel = (m_sel + 1) % 4;
        end else if (mask[0]) begin
            m_digit[m_sel] = (m_digit[m_sel] + 1) % 10;
        end else if (mask[1]) begin
            m_digit[m_sel] = (m_digit[m_sel] + 9) % 10;
        end
    endtask

    task automatic check_panel();
        check("ones", ones, m_digit[0]);
        check("tens", tens, m_digit[1]);
        check("hundreds", hundreds, m_digit[2]);
        check("thousands", thousands, m_digit[3]);
        check("sel", sel, m_sel);
    endtask

    task automatic press(input logic [3:0] mask, input bit edit);
        if (edit) model_apply(mask);
        @(posedge clk); #1;
        {btn_enter, btn_next, btn_dec, btn_inc} = mask;
        repeat (8) @(posedge clk);
        #1;
        {btn_enter, btn_next, btn_dec, btn_inc} = 4'b0000;
        repeat (8) @(posedge clk);
        @(negedge clk);
        check_panel();
    endtask

    task automatic set_number(input int n);
        int div[4];
        int target;
        div = '{1, 10, 100, 1000};
        for (int pos = 0; pos < 4; pos++) begin
            target = (n / div[pos]) % 10;
            for (int k = 0; k < 4 && m_sel != pos; k++) press(4'b0100, 1'b1);
            if ($urandom_range(0, 1) == 1) begin
                for (int k = 0; k < 10 && m_digit[pos] != target; k++) press(4'b0001, 1'b1);
            end else begin
                for (int k = 0; k < 10 && m_digit[pos] != target; k++) press(4'b0010, 1'b1);
            end
        end
    endtask

    task automatic wait_valid(input int budget);
        for (int k = 0; k < budget && !bus.value_valid; k++) @(negedge clk);
        check("valid_timeout", bus.value_valid, 1);
    endtask

    task automatic handshake();
        wait_valid(40);
        @(posedge clk); #1;
        bus.value_ready = 1'b1;
        @(posedge clk); #1;
        bus.value_ready = 1'b0;
        @(negedge clk);
        check("valid_after_hs", bus.value_valid, 0);
        check("busy_after_hs", busy, 0);
        check("value_kept", bus.value, last_value);
        check_panel();
    endtask

    // Monitor: on every rising value_valid, pop the oldest expected result
    int   busy_cyc = -1;
    logic prev_busy = 1'b0;
    logic prev_valid = 1'b0;
    always @(negedge clk) begin
        if (!reset) begin
            busy_cyc   = -1;
            prev_busy  = 1'b0;
            prev_valid = 1'b0;
        end else begin
            if (busy && !prev_busy) busy_cyc = 0;
            else if (busy_cyc >= 0) busy_cyc++;
            if (bus.value_valid && !prev_valid) begin
                check("latency", busy_cyc, 4);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_valid actual value %0d expected no result", bus.value);
                end else begin
                    check("value", bus.value, exp_q.pop_front());
                end
            end
            if (!busy) busy_cyc = -1;
            prev_busy  = busy;
            prev_valid = bus.value_valid;
        end
    end

    initial begin
        int n;
        bus.value_ready = 1'b0;
        m_digit = '{0, 0, 0, 0};
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_panel();
        check("reset_value", bus.value, 0);
        check("reset_valid", bus.value_valid, 0);
        check("reset_busy", busy, 0);
        @(posedge clk); #1;
        reset = 1'b1;

        // Short glitch is rejected; a long hold counts once
        @(posedge clk); #1;
        btn_inc = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        btn_inc = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("glitch_ones", ones, 0);
        @(posedge clk); #1;
        btn_inc = 1'b1;
        repeat (20) @(posedge clk);
        @(negedge clk);
        m_digit[0] = 1;
        check("hold_ones", ones, 1);
        @(posedge clk); #1;
        btn_inc = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("release_ones", ones, 1);

        // 1234, then hold the result while presses are ignored
        set_number(1234);
        press(4'b1000, 1'b1);
        wait_valid(40);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("hold_valid", bus.value_valid, 1);
            check("hold_value", bus.value, 1234);
        end
        press(4'b0001, 1'b0);
        press(4'b0100, 1'b0);
        check("hold_valid_after_press", bus.value_valid, 1);
        check("hold_busy", busy, 1);
        handshake();

        // Wrap-around in both directions
        set_number(0);
        for (int pos = 0; pos < 4; pos++) begin
            for (int k = 0; k < 4 && m_sel != pos; k++) press(4'b0100, 1'b1);
            press(4'b0010, 1'b1);
        end
        press(4'b1000, 1'b1);
        handshake();
        press(4'b0001, 1'b1);
        press(4'b0010, 1'b1);

        repeat (4) begin
            n = int'($urandom_range(0, 9999));
            set_number(n);
            press(4'b1000, 1'b1);
            handshake();
        end

        // Enter wins over inc in the same cycle
        set_number(5076);
        press(4'b1001, 1'b1);
        handshake();

        // Reset in the middle of a conversion
        @(posedge clk); #1;
        btn_enter = 1'b1;
        for (int k = 0; k < 20 && !busy; k++) @(negedge clk);
        check("convert_started", busy, 1);
        #1;
        reset = 1'b0;
        #1;
        m_digit = '{0, 0, 0, 0};
        m_sel = 0;
        exp_q.delete();
        check_panel();
        check("async_value", bus.value, 0);
        check("async_valid", bus.value_valid, 0);
        check("async_busy", busy, 0);
        btn_enter = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (30) @(posedge clk);
        @(negedge clk);
        check("no_valid_after_reset", bus.value_valid, 0);
        check("idle_after_reset", busy, 0);
        check_panel();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
